// File: rtl/seq_scan_pkg.sv
// Shared types for the "10001" scan controller: controller and detector state
// encodings plus the pattern length.
package seq_scan_pkg;

  localparam int PATTERN_LEN = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  typedef enum logic [2:0] {
    DET_S0,
    DET_S1,
    DET_S10,
    DET_S100,
    DET_S1000,
    DET_S10001
  } det_state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Producer/consumer handshakes and detector observation signals of seq_scan_ctrl.
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             det_din;
  logic             det_dout;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_count, out_valid, busy, det_din, det_dout
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_count, out_valid, busy, det_din, det_dout
  );
endinterface

// File: rtl/seq10001_det.sv
// Moore detector for the serial pattern "10001" with overlapping matches.
// State only advances while en is high; clr returns it to S0.
module seq10001_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= DET_S0;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // After a hit the trailing "1" is the start of the next candidate match.
  always_comb begin
    state_d = DET_S0;
    case (state_q)
      DET_S0:     state_d = din ? DET_S1     : DET_S0;
      DET_S1:     state_d = din ? DET_S1     : DET_S10;
      DET_S10:    state_d = din ? DET_S1     : DET_S100;
      DET_S100:   state_d = din ? DET_S1     : DET_S1000;
      DET_S1000:  state_d = din ? DET_S10001 : DET_S0;
      DET_S10001: state_d = din ? DET_S1     : DET_S10;
      default:    state_d = DET_S0;
    endcase
  end

  assign dout = (state_q == DET_S10001);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a parallel word, shifts it MSB-first through the "10001" detector,
// and returns the number of hits over a valid/ready result handshake.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 6,
  parameter int CONTINUOUS = 0
) (
  input  logic          clk,
  input  logic          clr,
  seq_scan_ctrl_if.slave bus
);

  localparam int BW = $clog2(WIDTH);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             det_clr;
  logic             det_en;
  logic             det_dout;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = count_q;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          shreg_d  = bus.in_data;
          bitcnt_d = '0;
          count_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        // First shift cycle still shows the previous word's final detector state.
        if (det_dout && (bitcnt_q != '0) && (count_q != '1)) begin
          count_d = count_q + 1'b1;
        end
        if (bitcnt_q == BW'(WIDTH - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (det_dout && (count_q != '1)) begin
          count_d = count_q + 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign det_clr = clr | (accept & (CONTINUOUS == 0));
  assign det_en  = (state_q == ST_SHIFT);

  seq10001_det u_det (
    .clk  (clk),
    .clr  (det_clr),
    .en   (det_en),
    .din  (bus.det_din),
    .dout (det_dout)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_count = count_q;
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign bus.det_din   = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
  assign bus.det_dout  = det_dout;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench: two controllers (per-word and continuous detector)
// driven in lockstep and checked against a bit-history pattern model.
module tb_seq_scan_ctrl;

  localparam int W  = 16;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   hist_c[$];

  seq_scan_ctrl_if #(.WIDTH(W), .CNT_W(CW)) if0 ();
  seq_scan_ctrl_if #(.WIDTH(W), .CNT_W(CW)) if1 ();

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW), .CONTINUOUS(0)) u0 (
    .clk (clk),
    .clr (clr),
    .bus (if0)
  );

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW), .CONTINUOUS(1)) u1 (
    .clk (clk),
    .clr (clr),
    .bus (if1)
  );

  always #5 clk = ~clk;

  // Hits = positions where the last five bits seen equal 1,0,0,0,1.
  function automatic int model_hits(input logic [W-1:0] w, input bit cont);
    bit h[$];
    int hits = 0;
    if (cont) h = hist_c;
    for (int i = W - 1; i >= 0; i--) begin
      h.push_back(w[i]);
      if (h.size() > 5) void'(h.pop_front());
      if (h.size() == 5 && h[0] && !h[1] && !h[2] && !h[3] && h[4]) hits++;
    end
    if (cont) hist_c = h;
    return hits;
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    if0.in_valid = iv;  if1.in_valid = iv;
    if0.in_data = d;    if1.in_data = d;
    if0.out_ready = ordy; if1.out_ready = ordy;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    hist_c.delete();
  endtask

  task automatic run_word(input logic [W-1:0] w, input int hold, input bit poke,
                          output int got0, output int got1);
    int e0, e1, n, douts;
    bit bad, bad2;
    logic [W-1:0] seq;
    logic [CW-1:0] c0, c1;
    e0 = model_hits(w, 1'b0);
    e1 = model_hits(w, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1)
      begin n_err++; $display("FAIL in_ready_idle word=%h got=%b%b want=11", w, if0.in_ready, if1.in_ready); end
    drive(1'b1, w, 1'b0);
    @(negedge clk);
    drive(1'b0, W'($urandom), 1'b0);
    n = 1; douts = 0; bad = 0; seq = '0;
    while (if0.out_valid !== 1'b1 && n < 40) begin
      if (if0.busy !== 1'b1 || if1.busy !== 1'b1 || if0.in_ready !== 1'b0) bad = 1;
      if (n <= W) seq = {seq[W-2:0], if0.det_din};
      else if (if0.det_din !== 1'b0) bad = 1;
      if (if0.det_dout === 1'b1) douts++;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != W + 2)
      begin n_err++; $display("FAIL latency word=%h got=%0d want=%0d", w, n, W + 2); end
    n_cmp++;
    if (bad)
      begin n_err++; $display("FAIL busy_shift word=%h got=bad_busy_or_ready want=busy_only", w); end
    n_cmp++;
    if (seq !== w)
      begin n_err++; $display("FAIL det_din_seq got=%h want=%h", seq, w); end
    n_cmp++;
    if (douts != e0)
      begin n_err++; $display("FAIL det_dout_pulses word=%h got=%0d want=%0d", w, douts, e0); end
    n_cmp++;
    if (if1.out_valid !== 1'b1)
      begin n_err++; $display("FAIL out_valid_cont word=%h got=%b want=1", w, if1.out_valid); end
    got0 = int'(if0.out_count);
    got1 = int'(if1.out_count);
    n_cmp++;
    if (got0 != e0)
      begin n_err++; $display("FAIL count_word word=%h got=%0d want=%0d", w, got0, e0); end
    n_cmp++;
    if (got1 != e1)
      begin n_err++; $display("FAIL count_cont word=%h got=%0d want=%0d", w, got1, e1); end
    c0 = if0.out_count; c1 = if1.out_count; bad2 = 0;
    for (int i = 0; i < hold; i++) begin
      drive(poke && (i == hold / 2), W'($urandom), 1'b0);
      @(negedge clk);
      if (if0.out_valid !== 1'b1 || if1.out_valid !== 1'b1 || if0.in_ready !== 1'b0 ||
          if0.out_count !== c0 || if1.out_count !== c1) bad2 = 1;
    end
    n_cmp++;
    if (bad2)
      begin n_err++; $display("FAIL done_hold word=%h got=unstable want=stable hold=%0d", w, hold); end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    n_cmp++;
    if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0 || if0.busy !== 1'b0 || if1.in_ready !== 1'b1)
      begin n_err++; $display("FAIL return_idle word=%h got=rdy%b vld%b busy%b want=rdy1 vld0 busy0", w, if0.in_ready, if0.out_valid, if0.busy); end
    $display("word=%h hold=%0d count0=%0d/%0d count1=%0d/%0d lat=%0d", w, hold, got0, e0, got1, e1, n);
  endtask

  task automatic test_reset();
    do_clr();
    @(negedge clk);
    n_cmp++;
    if ({if0.in_ready, if1.in_ready} !== 2'b11)
      begin n_err++; $display("FAIL reset_in_ready got=%b%b want=11", if0.in_ready, if1.in_ready); end
    n_cmp++;
    if ({if0.out_valid, if1.out_valid, if0.busy, if1.busy} !== 4'b0000)
      begin n_err++; $display("FAIL reset_valid_busy got=%b%b%b%b want=0000", if0.out_valid, if1.out_valid, if0.busy, if1.busy); end
    n_cmp++;
    if (if0.out_count !== '0 || if1.out_count !== '0 || if0.det_din !== 1'b0)
      begin n_err++; $display("FAIL reset_count got=%0d/%0d want=0", if0.out_count, if1.out_count); end
    $display("reset checked");
  endtask

  task automatic test_single_hit();
    int g0, g1;
    run_word(16'h8800, 0, 1'b0, g0, g1);
    n_cmp++;
    if (g0 != 1 || g1 != 1)
      begin n_err++; $display("FAIL single_hit got=%0d/%0d want=1/1", g0, g1); end
  endtask

  task automatic test_overlap();
    int g0, g1;
    logic [W-1:0] words [3];
    int want [3];
    words = '{16'h8888, 16'h0000, 16'hFFFF};
    want  = '{3, 0, 0};
    for (int k = 0; k < 3; k++) begin
      run_word(words[k], 0, 1'b0, g0, g1);
      n_cmp++;
      if (g0 != want[k])
        begin n_err++; $display("FAIL overlap word=%h got=%0d want=%0d", words[k], g0, want[k]); end
    end
  endtask

  task automatic test_back_pressure();
    int g0, g1;
    run_word(16'h8888, 10, 1'b1, g0, g1);
    n_cmp++;
    if (g0 != 3)
      begin n_err++; $display("FAIL back_pressure got=%0d want=3", g0); end
  endtask

  task automatic test_cross_word();
    int g0, g1;
    do_clr();
    run_word(16'h0008, 0, 1'b0, g0, g1);
    n_cmp++;
    if (g0 != 0 || g1 != 0)
      begin n_err++; $display("FAIL cross_first got=%0d/%0d want=0/0", g0, g1); end
    run_word(16'h8000, 1, 1'b0, g0, g1);
    n_cmp++;
    if (g0 != 0 || g1 != 1)
      begin n_err++; $display("FAIL cross_second got=%0d/%0d want=0/1", g0, g1); end
  endtask

  task automatic test_reset_mid();
    int g0, g1;
    bit seen;
    @(negedge clk);
    drive(1'b1, 16'h8888, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    hist_c.delete();
    n_cmp++;
    if (if0.in_ready !== 1'b1 || if0.busy !== 1'b0 || if0.out_valid !== 1'b0 || if0.out_count !== '0 ||
        if0.det_din !== 1'b0 || if0.det_dout !== 1'b0 || if1.busy !== 1'b0 || if1.out_count !== '0)
      begin n_err++; $display("FAIL reset_mid got=rdy%b busy%b vld%b cnt%0d want=rdy1 busy0 vld0 cnt0", if0.in_ready, if0.busy, if0.out_valid, if0.out_count); end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0 || if0.in_ready !== 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen)
      begin n_err++; $display("FAIL reset_mid_quiet got=activity want=idle"); end
    $display("reset mid-shift checked");
    run_word(16'h8800, 0, 1'b0, g0, g1);
    n_cmp++;
    if (g0 != 1 || g1 != 1)
      begin n_err++; $display("FAIL reset_mid_fresh got=%0d/%0d want=1/1", g0, g1); end
  endtask

  task automatic test_random();
    int g0, g1, p;
    logic [W-1:0] w;
    for (int k = 0; k < 24; k++) begin
      w = W'($urandom);
      if ($urandom_range(1) == 1) begin
        p = $urandom_range(W - 5);
        w = (w & ~(W'(5'h1F) << p)) | (W'(5'b10001) << p);
      end
      run_word(w, $urandom_range(3), 1'b1, g0, g1);
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_single_hit();
    test_overlap();
    test_back_pressure();
    test_cross_word();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
